// File: rtl/dino_jump_if.sv
// dino_jump_if: frame tick, button inputs and sprite motion/status outputs of the dino jump controller
interface dino_jump_if #(parameter int Y_W = 8);
    logic           i_tick;
    logic           i_jump_pulse;
    logic           i_duck;
    logic           i_freeze;
    logic [Y_W-1:0] o_dino_y;
    logic [2:0]     o_state;
    logic           o_airborne;
    logic           o_ducking;
    logic           o_land_pulse;
    modport master (
        output i_tick, i_jump_pulse, i_duck, i_freeze,
        input  o_dino_y, o_state, o_airborne, o_ducking, o_land_pulse
    );
    modport slave (
        input  i_tick, i_jump_pulse, i_duck, i_freeze,
        output o_dino_y, o_state, o_airborne, o_ducking, o_land_pulse
    );
endinterface

// File: rtl/dino_jump_ctrl.sv
// dino_jump_ctrl: tick-gated jump/hover/fall/duck controller producing the dino height and status flags
module dino_jump_ctrl #(
    parameter int Y_W         = 8,
    parameter int JUMP_HEIGHT = 64,
    parameter int RISE_STEP   = 8,
    parameter int FALL_STEP   = 4,
    parameter int HOVER_TICKS = 3
) (
    input  logic      clk,
    input  logic      rst,
    dino_jump_if.slave bus
);
    localparam int H_W = HOVER_TICKS > 1 ? $clog2(HOVER_TICKS) : 1;
    localparam logic [Y_W:0] JH  = (Y_W+1)'(JUMP_HEIGHT);
    localparam logic [Y_W:0] RS  = (Y_W+1)'(RISE_STEP);
    localparam logic [Y_W:0] FS1 = (Y_W+1)'(FALL_STEP);
    localparam logic [Y_W:0] FS2 = (Y_W+1)'(2 * FALL_STEP);
    localparam logic [H_W-1:0] H_LAST = H_W'(HOVER_TICKS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RISE  = 3'd1,
        S_HOVER = 3'd2,
        S_FALL  = 3'd3,
        S_DUCK  = 3'd4
    } state_t;

    state_t         r_state, w_state;
    logic [Y_W-1:0] r_y, w_y;
    logic [H_W-1:0] r_hcnt, w_hcnt;
    logic           r_buf, w_buf;
    logic           r_land, w_land;
    logic [Y_W:0]   w_sum;
    logic [Y_W:0]   w_step;

    assign w_sum  = {1'b0, r_y} + RS;
    assign w_step = bus.i_duck ? FS2 : FS1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_y     <= '0;
            r_hcnt  <= '0;
            r_buf   <= 1'b0;
            r_land  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_y     <= w_y;
            r_hcnt  <= w_hcnt;
            r_buf   <= w_buf;
            r_land  <= w_land;
        end
    end

    always_comb begin
        w_state = r_state;
        w_y     = r_y;
        w_hcnt  = r_hcnt;
        w_buf   = r_buf;
        w_land  = 1'b0;
        if (!bus.i_freeze) begin
            case (r_state)
                S_IDLE, S_DUCK: begin
                    if (bus.i_jump_pulse) begin
                        w_state = S_RISE;
                        w_buf   = 1'b0;
                    end else if (bus.i_duck) begin
                        w_state = S_DUCK;
                    end else begin
                        w_state = S_IDLE;
                    end
                end
                S_RISE: begin
                    if (bus.i_duck) begin
                        w_state = S_FALL;
                    end else if (bus.i_tick) begin
                        w_y = w_sum >= JH ? JH[Y_W-1:0] : w_sum[Y_W-1:0];
                        if (w_sum >= JH) begin
                            w_state = S_HOVER;
                            w_hcnt  = '0;
                        end
                    end
                end
                S_HOVER: begin
                    if (bus.i_duck) begin
                        w_state = S_FALL;
                    end else if (bus.i_tick) begin
                        w_hcnt  = r_hcnt + 1'b1;
                        w_state = r_hcnt == H_LAST ? S_FALL : S_HOVER;
                    end
                end
                S_FALL: begin
                    w_buf = r_buf | bus.i_jump_pulse;
                    if (bus.i_tick) begin
                        if ({1'b0, r_y} <= w_step) begin
                            w_y     = '0;
                            w_land  = 1'b1;
                            w_state = w_buf ? S_RISE : S_IDLE;
                            w_buf   = 1'b0;
                        end else begin
                            w_y = r_y - w_step[Y_W-1:0];
                        end
                    end
                end
                default: w_state = S_IDLE;
            endcase
        end
    end

    assign bus.o_dino_y     = r_y;
    assign bus.o_state      = r_state;
    assign bus.o_airborne   = r_state inside {S_RISE, S_HOVER, S_FALL};
    assign bus.o_ducking    = r_state == S_DUCK;
    assign bus.o_land_pulse = r_land;
endmodule

// File: tb/tb_dino_jump_ctrl.sv
// tb_dino_jump_ctrl: directed and randomized checks of dino_jump_ctrl against a behavioural model
module tb_dino_jump_ctrl;
    localparam int JH = 64, RS = 8, FS = 4, HT = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   ms, my, mh;
    bit   mb, ml;

    always #5 clk = ~clk;

    dino_jump_if #(.Y_W(8)) bus ();
    dino_jump_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic chk(input string tag, input logic [31:0] got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model(input bit t, input bit j, input bit d, input bit f, input bit r);
        int s;
        ml = 0;
        if (r) begin
            ms = 0; my = 0; mh = 0; mb = 0;
        end else if (!f) begin
            if (ms == 0 || ms == 4) begin
                if (j) begin ms = 1; mb = 0; end
                else ms = d ? 4 : 0;
            end else if (ms == 1 || ms == 2) begin
                if (d) ms = 3;
                else if (t && ms == 1) begin
                    my = (my + RS > JH) ? JH : my + RS;
                    if (my == JH) begin ms = 2; mh = 0; end
                end else if (t) begin
                    mh++;
                    if (mh == HT) ms = 3;
                end
            end else if (ms == 3) begin
                if (j) mb = 1;
                if (t) begin
                    s = d ? 2 * FS : FS;
                    if (my <= s) begin
                        my = 0; ml = 1; ms = mb ? 1 : 0; mb = 0;
                    end else my -= s;
                end
            end
        end
    endtask

    task automatic step(input bit t, input bit j, input bit d, input bit f, input bit r);
        bus.i_tick = t; bus.i_jump_pulse = j; bus.i_duck = d; bus.i_freeze = f; rst = r;
        @(posedge clk);
        model(t, j, d, f, r);
        #1;
        chk("state", bus.o_state, ms);
        chk("y", bus.o_dino_y, my);
        chk("airborne", bus.o_airborne, int'(ms >= 1 && ms <= 3));
        chk("ducking", bus.o_ducking, int'(ms == 4));
        chk("land", bus.o_land_pulse, int'(ml));
    endtask

    initial begin
        bit d;
        bus.i_tick = 0; bus.i_jump_pulse = 0; bus.i_duck = 0; bus.i_freeze = 0;
        repeat (2) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1);
        chk("rst_state", bus.o_state, 0);
        chk("rst_y", bus.o_dino_y, 0);
        chk("rst_flags", {bus.o_airborne, bus.o_ducking, bus.o_land_pulse}, 0);
        step(0, 0, 0, 0, 0);

        step(0, 1, 0, 0, 0);
        chk("jump_rise", bus.o_state, 1);
        for (int i = 0; i < 8; i++) begin
            step(1, 0, 0, 0, 0);
            chk("rise_y", bus.o_dino_y, 8 * (i + 1));
            step(0, 0, 0, 0, 0);
        end
        chk("apex_hover", bus.o_state, 2);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 0, 0);
            chk("hover_len", bus.o_state, i == 2 ? 3 : 2);
        end
        for (int i = 0; i < 16; i++) begin
            step(1, 0, 0, 0, 0);
            chk("fall_y", bus.o_dino_y, 60 - 4 * i);
            chk("fall_land", bus.o_land_pulse, int'(i == 15));
            step(0, 0, 0, 0, 0);
            chk("land_once", bus.o_land_pulse, 0);
        end
        chk("landed_idle", bus.o_state, 0);

        step(0, 1, 0, 0, 0);
        repeat (22) step(1, 0, 0, 0, 0);
        chk("buf_y20", bus.o_dino_y, 20);
        chk("buf_fall", bus.o_state, 3);
        step(0, 1, 0, 0, 0);
        repeat (4) step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("relaunch_land", bus.o_land_pulse, 1);
        chk("relaunch_state", bus.o_state, 1);
        step(1, 0, 0, 0, 0);
        chk("relaunch_y", bus.o_dino_y, 8);

        repeat (3) step(1, 0, 0, 0, 0);
        chk("ff_y32", bus.o_dino_y, 32);
        step(0, 0, 1, 0, 0);
        chk("ff_state", bus.o_state, 3);
        chk("ff_hold_y", bus.o_dino_y, 32);
        step(1, 0, 1, 0, 0); chk("ff_y24", bus.o_dino_y, 24);
        step(1, 0, 1, 0, 0); chk("ff_y16", bus.o_dino_y, 16);
        step(1, 0, 0, 0, 0); chk("ff_rel_y12", bus.o_dino_y, 12);
        step(1, 0, 1, 0, 0); chk("ff_y4", bus.o_dino_y, 4);
        step(1, 0, 1, 0, 0);
        chk("ff_land_y", bus.o_dino_y, 0);
        chk("ff_land_state", bus.o_state, 0);

        step(0, 0, 1, 0, 0);
        chk("duck_state", bus.o_state, 4);
        chk("duck_flag", bus.o_ducking, 1);
        step(0, 1, 1, 0, 0);
        chk("duck_jump", bus.o_state, 1);
        step(0, 0, 0, 0, 1);
        step(0, 1, 1, 0, 0);
        chk("jump_over_duck", bus.o_state, 1);

        step(0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0);
        repeat (5) step(1, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(1, i == 4, 0, 1, 0);
        chk("frz_y", bus.o_dino_y, 40);
        chk("frz_state", bus.o_state, 1);
        step(1, 0, 0, 0, 0);
        chk("frz_resume", bus.o_dino_y, 48);
        step(0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0);
        repeat (5) step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1);
        chk("midrst_state", bus.o_state, 0);
        chk("midrst_y", bus.o_dino_y, 0);

        d = 0;
        for (int i = 0; i < 4000; i++) begin
            d = d ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 19) == 0);
            step(1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0, d,
                 $urandom_range(0, 19) == 0, $urandom_range(0, 399) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
